// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start, 8 data bits LSB-first, parity, STOP_BITS stop bits.
// Optional input parity checker enabled by defining PARITY_FRAME_TX_CHECK_EN.
module parity_frame_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] data_in,
  input  logic       parity_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx_out,
  output logic       busy,
  output logic       parity_err
);

  localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX  = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("parity_frame_tx: CLKS_PER_BIT must be >= 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("parity_frame_tx: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Reset asserts asynchronously, deasserts two clock edges later.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          tx_d, ready_d, busy_d;
  logic          bit_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx_out     <= 1'b1;
      data_ready <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tx_out     <= tx_d;
      data_ready <= ready_d;
      busy       <= busy_d;
    end
  end

  assign bit_end = (baud_q == BAUD_MAX);

  // Outputs are computed one cycle ahead so every port comes straight from a flop.
  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? '0 : baud_q + BW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_out;
    ready_d = data_ready;
    busy_d  = busy;
    case (state_q)
      IDLE: begin
        baud_d  = '0;
        idx_d   = '0;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (data_valid && data_ready) begin
          shift_d = data_in;
          par_d   = parity_in;
          state_d = START;
          tx_d    = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: if (bit_end) begin
        state_d = DATA;
        tx_d    = shift_q[0];
      end
      DATA: if (bit_end) begin
        if (idx_q == 3'd7) begin
          state_d = PARITY;
          idx_d   = '0;
          tx_d    = par_q;
        end else begin
          idx_d   = idx_q + 3'd1;
          shift_d = shift_q >> 1;
          tx_d    = shift_q[1];
        end
      end
      PARITY: if (bit_end) begin
        state_d = STOP;
        tx_d    = 1'b1;
      end
      STOP: if (bit_end) begin
        if (idx_q == STOP_LAST) begin
          state_d = IDLE;
          idx_d   = '0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          idx_d   = idx_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PARITY_FRAME_TX_CHECK_EN
  logic accept;
  assign accept = (state_q == IDLE) && data_valid && data_ready;

  // Flags only; the frame still carries the parity bit as received.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   parity_err <= 1'b0;
    else if (accept && ((^data_in) != parity_in)) parity_err <= 1'b1;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_parity_frame_tx.sv
// Directed bench for parity_frame_tx: queue of expected frames checked by a line monitor,
// plus a STOP_BITS=2 instance checked cycle by cycle.
module tb_parity_frame_tx;

  localparam int CPB = 4;
`ifdef PARITY_FRAME_TX_CHECK_EN
  localparam logic EXP_PE = 1'b1;
`else
  localparam logic EXP_PE = 1'b0;
`endif

  logic       clk, reset_n;
  logic [7:0] data_in, data_in2;
  logic       parity_in, parity_in2, data_valid, data_valid2;
  logic       data_ready, tx_out, busy, parity_err;
  logic       data_ready2, tx_out2, busy2, parity_err2;

  int n_cmp = 0, n_fail = 0, frames_seen = 0, frames_exp = 0;
  bit mon_en = 1'b1;
  logic [10:0] exp_q[$];

  parity_frame_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .parity_in(parity_in),
    .data_valid(data_valid), .data_ready(data_ready), .tx_out(tx_out),
    .busy(busy), .parity_err(parity_err));

  parity_frame_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .data_in(data_in2), .parity_in(parity_in2),
    .data_valid(data_valid2), .data_ready(data_ready2), .tx_out(tx_out2),
    .busy(busy2), .parity_err(parity_err2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag, output int n);
    n = 0;
    while (data_ready !== 1'b1 && n < 200) begin
      tick;
      n++;
    end
    chk({tag, "_in_time"}, n < 200, 1);
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic p);
    exp_q.push_back({1'b1, p, d, 1'b0});
    frames_exp++;
  endtask

  task automatic send(input logic [7:0] d, input logic p, input bit track);
    int n;
    wait_ready("send_rdy", n);
    data_in    = d;
    parity_in  = p;
    data_valid = 1'b1;
    if (track) expect_frame(d, p);
    tick;
    data_valid = 1'b0;
    chk("accept_tx_busy_ready", {tx_out, busy, data_ready}, 3'b010);
  endtask

  // Line monitor: samples every cycle of a frame, compares against the queue head.
  initial begin : monitor
    logic [10:0] got;
    logic [10:0] e;
    bit hold_bad, hs_bad;
    forever begin
      @(negedge clk);
      if (mon_en && reset_n === 1'b1 && tx_out === 1'b0) begin
        hold_bad = 1'b0;
        hs_bad   = 1'b0;
        got      = '0;
        for (int b = 0; b < 11; b++) begin
          for (int c = 0; c < CPB; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (c == 0) got[b] = tx_out;
            else if (tx_out !== got[b]) hold_bad = 1'b1;
            if (busy !== 1'b1 || data_ready !== 1'b0) hs_bad = 1'b1;
          end
        end
        @(negedge clk);
        chk("idle_after_frame", {tx_out, data_ready, busy}, 3'b110);
        chk("bit_hold", hold_bad, 0);
        chk("busy_ready_in_frame", hs_bad, 0);
        frames_seen++;
        chk("frame_was_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("frame_bits", got, e);
        end
      end
    end
  end

  initial begin : stim
    int n;
    logic [11:0] frame2;
    reset_n = 1'b1; data_valid = 1'b0; data_in = '0; parity_in = 1'b0;
    data_valid2 = 1'b0; data_in2 = '0; parity_in2 = 1'b0;
    #2 reset_n = 1'b0;
    repeat (3) tick;
    chk("reset_vals", {tx_out, data_ready, busy, parity_err}, 4'b1100);
    chk("reset_vals2", {tx_out2, data_ready2, busy2, parity_err2}, 4'b1100);
    reset_n = 1'b1;
    repeat (4) tick;
    chk("post_reset", {tx_out, data_ready, busy}, 3'b110);

    // 0xA5, 44-cycle frame, ready back in cycle 45
    send(8'hA5, 1'b0, 1'b1);
    wait_ready("t1", n);
    chk("t1_frame_len", n, 44);
    chk("t1_idle_tx", tx_out, 1);
    repeat (3) tick;

    // back-to-back with data_valid held high
    wait_ready("t2_rdy", n);
    data_in = 8'h00; parity_in = 1'b0; data_valid = 1'b1;
    expect_frame(8'h00, 1'b0);
    tick;
    data_in = 8'hFF; parity_in = 1'b0;
    expect_frame(8'hFF, 1'b0);
    wait_ready("t2_gap", n);
    chk("t2_gap_len", n, 44);
    chk("t2_idle_tx", tx_out, 1);
    tick;
    chk("t2_restart", {tx_out, busy, data_ready}, 3'b010);
    data_valid = 1'b0;
    wait_ready("t2_end", n);
    repeat (3) tick;

    // STOP_BITS=2 instance, 0x01 parity 1
    data_in2 = 8'h01; parity_in2 = 1'b1; data_valid2 = 1'b1;
    frame2 = {2'b11, 1'b1, 8'h01, 1'b0};
    tick;
    data_valid2 = 1'b0;
    for (int k = 0; k < 12 * CPB; k++) begin
      chk("t3_line", {tx_out2, busy2, data_ready2}, {frame2[k / CPB], 2'b10});
      tick;
    end
    chk("t3_end", {tx_out2, busy2, data_ready2}, 3'b101);

    // valid pulse and data change mid-frame are ignored
    send(8'h5A, 1'b0, 1'b1);
    repeat (10) tick;
    data_in = 8'h3C; parity_in = 1'b0; data_valid = 1'b1;
    tick;
    data_valid = 1'b0;
    repeat (5) tick;
    data_in = 8'hFF;
    wait_ready("t4_end", n);
    repeat (60) tick;
    chk("t4_no_second_frame", {busy, data_ready, tx_out}, 3'b011);
    chk("t4_queue_empty", exp_q.size(), 0);

    // reset in the middle of DATA
    mon_en = 1'b0;
    send(8'h00, 1'b0, 1'b0);
    repeat (15) tick;
    chk("t5_pre_reset", {tx_out, busy}, 2'b01);
    #3 reset_n = 1'b0;
    #1;
    chk("t5_async_reset", {tx_out, busy, data_ready}, 3'b101);
    repeat (2) tick;
    reset_n = 1'b1;
    repeat (4) tick;
    chk("t5_post_release", {tx_out, busy, data_ready}, 3'b101);
    mon_en = 1'b1;
    send(8'h5C, 1'b0, 1'b1);
    wait_ready("t5_end", n);
    chk("t5_frame_len", n, 44);
    repeat (3) tick;

    // wrong parity in: flag (when enabled) but send as received
    chk("t6_pe_clean", parity_err, 0);
    send(8'h07, 1'b0, 1'b1);
    chk("t6_pe_after_accept", parity_err, EXP_PE);
    wait_ready("t6_end", n);
    repeat (3) tick;
    chk("t6_pe_sticky", parity_err, EXP_PE);

    repeat (5) tick;
    chk("queue_drained", exp_q.size(), 0);
    chk("frames_seen", frames_seen, frames_exp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/parity_frame_tx.md
Name: parity_frame_tx

Overview:
Serial frame transmitter that consumes the byte and parity bit produced by the upstream even-parity generator.
Each accepted byte is shifted out LSB-first as one line frame: start bit (0), 8 data bits, parity bit, STOP_BITS stop bits (1).
A valid/ready handshake on the input side throttles the upstream stage while a frame is in flight.

Parameters:
CLKS_PER_BIT, 16, clock cycles each line bit is held; legal range >= 2
STOP_BITS, 1, number of stop bits per frame; legal values 1 or 2

Ports:
clk  input  1  system clock; all state changes on rising edge
reset_n  input  1  asynchronous, active-low reset
data_in  input  8  byte to transmit
parity_in  input  1  even parity of data_in, from the upstream parity stage
data_valid  input  1  data_in/parity_in valid this cycle
data_ready  output  1  block can accept a byte this cycle
tx_out  output  1  serial line; idle high
busy  output  1  frame in progress
parity_err  output  1  sticky parity-mismatch flag (optional feature only)

Behaviour:
- Clock and reset: one clock, clk. Reset is reset_n, asynchronous assert, active-low, release synchronised to clk.
- Reset values: tx_out=1, data_ready=1, busy=0, parity_err=0, state=IDLE, all counters 0.
- Reset asserted mid-frame: tx_out returns to 1 immediately and the frame is discarded; no partial frame resumes after release.
- All outputs are registered.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - data_ready=1, busy=0, tx_out=1.
  - On data_valid & data_ready, latch data_in and parity_in into the shift register and go to START.
  - Next cycle: data_ready=0, busy=1.
- START: tx_out=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - tx_out = shift_reg[0], held CLKS_PER_BIT cycles per bit.
  - Shift right after each bit; 3-bit index counts 0..7.
  - After bit 7, go to PARITY.
- PARITY: tx_out = latched parity bit for CLKS_PER_BIT cycles.
- STOP:
  - tx_out=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE.
  - In the first IDLE cycle, data_ready=1 and busy=0.
- Timing:
  - Baud counter width is $clog2(CLKS_PER_BIT); it wraps to 0 at CLKS_PER_BIT-1, which advances the bit.
  - Latency: the start bit appears on tx_out on the cycle after the accepting edge.
  - Frame length is exactly (10+STOP_BITS)*CLKS_PER_BIT cycles.
  - Minimum spacing between accepts is frame length + 1 cycle.
- Input side:
  - data_valid while data_ready=0 is ignored; nothing is queued.
  - Changes on data_in/parity_in during a frame do not affect the frame.
  - data_valid held high continuously gives back-to-back frames, each separated by one IDLE cycle (tx_out=1).
- Out-of-range parameters: CLKS_PER_BIT<2 or STOP_BITS outside {1,2} is a compile-time error (elaboration check).

Optional Feature:
Macro: PARITY_FRAME_TX_CHECK_EN
- Defined:
  - On accept, the block recomputes the XOR of data_in and compares it with parity_in.
  - On mismatch, parity_err sets in the cycle after accept and stays 1 until reset.
  - The frame is still sent using the received parity_in, unchanged.
- Not defined: no checker logic; parity_err is tied to 0.

Test Plan:
1. CLKS_PER_BIT=4, STOP_BITS=1, send 0xA5 with parity_in=0 -> data_ready drops the next cycle; tx_out shows 0,1,0,1,0,0,1,0,1,0,1, each bit held 4 cycles (44 cycles total); busy=1 throughout; data_ready=1 in cycle 45.
2. data_valid held high with bytes 0x00 (parity 0) then 0xFF (parity 0) -> two frames, a single tx_out=1 idle cycle between them, second frame data bits all 1.
3. STOP_BITS=2, send 0x01 with parity 1 -> stop high for 8 cycles; frame length 48 cycles.
4. data_valid pulsed and data_in changed to 0x3C mid-frame -> ignored; transmitted frame unchanged; no second frame.
5. reset_n driven low during the DATA state -> tx_out=1 and busy=0 asynchronously; after release, data_ready=1 and the next byte sends a complete frame.
6. With PARITY_FRAME_TX_CHECK_EN: send 0x07 with parity_in=0 -> parity_err=1 one cycle after accept and stays 1; frame carries parity bit 0. Without the macro the same stimulus leaves parity_err=0.
